// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC / branch stage: condition codes, sequencer states, flag layout.
package pc_branch_unit_pkg;

    localparam int unsigned COND_W = 3;
    localparam int unsigned FLAG_W = 3;

    // Flag register bit order is {Z,N,P}
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_P = 0;

    typedef enum logic [COND_W-1:0] {
        COND_AL = 3'b000,
        COND_Z  = 3'b001,
        COND_NZ = 3'b010,
        COND_N  = 3'b011,
        COND_NN = 3'b100,
        COND_P  = 3'b101,
        COND_NP = 3'b110,
        COND_NV = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/pc_branch_unit_branch_cond.sv
// Combinational branch-condition evaluator over the {Z,N,P} flags.
module branch_cond
    import pc_branch_unit_pkg::*;
(
    input  logic [COND_W-1:0] br_cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              cond_true
);

    // Select the flag test named by the condition code
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(br_cond))
            COND_AL: cond_true = 1'b1;
            COND_Z:  cond_true = flags[FLAG_Z];
            COND_NZ: cond_true = ~flags[FLAG_Z];
            COND_N:  cond_true = flags[FLAG_N];
            COND_NN: cond_true = ~flags[FLAG_N];
            COND_P:  cond_true = flags[FLAG_P];
            COND_NP: cond_true = ~flags[FLAG_P];
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register, flag register and RUN/FLUSH/HALT sequencer fed by the ALU flags.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned OFF_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flags_we,
    input  logic              zero_in,
    input  logic              neg_in,
    input  logic              par_in,
    input  logic              br_valid,
    input  logic [COND_W-1:0] br_cond,
    input  logic [OFF_W-1:0]  br_off,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic [FLAG_W-1:0] flags_q,
    output logic              taken,
    output logic              flush,
    output logic              halted
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [FLAG_W-1:0]   flags_d;
    logic                flush_q, flush_d;
    logic                halted_q, halted_d;

    logic [FLAG_W-1:0]   flags_in;
    logic [FLAG_W-1:0]   eff_flags;
    logic                cond_true;
    logic                br_hit;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   br_target;

    // Bypass the flags written by the current instruction into the branch test
    always_comb begin
        flags_in  = {zero_in, neg_in, par_in};
        eff_flags = flags_we ? flags_in : flags_q;
        pc_inc    = pc_q + ADDR_W'(1);
        br_target = pc_q + ADDR_W'($signed(br_off));
        br_hit    = br_valid & cond_true;
    end

    branch_cond u_branch_cond (
        .br_cond   (br_cond),
        .flags     (eff_flags),
        .cond_true (cond_true)
    );

    // Next-state, next-PC and flag update; stall holds every register
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flags_d  = flags_q;
        flush_d  = flush_q;
        halted_d = halted_q;
        if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (flags_we) flags_d = flags_in;
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (jmp_valid) begin
                        pc_d    = jmp_target;
                        state_d = ST_FLUSH;
                    end else if (br_hit) begin
                        pc_d    = br_target;
                        state_d = ST_FLUSH;
                    end else begin
                        pc_d    = pc_inc;
                    end
                end
                ST_FLUSH: begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
            flush_d  = (state_d == ST_FLUSH);
            halted_d = (state_d == ST_HALT);
        end
    end

    // State, PC, flag and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            flags_q  <= '0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flags_q  <= flags_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

    assign pc        = pc_q;
    assign link_addr = pc_inc;
    assign flush     = flush_q;
    assign halted    = halted_q;
    assign taken     = (state_q == ST_RUN) & (jmp_valid | br_hit);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus randomized run against a model.
module tb_pc_branch_unit;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned OFF_W  = 8;
    localparam int          PC_MOD = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic              flags_we = 1'b0;
    logic              zero_in = 1'b0, neg_in = 1'b0, par_in = 1'b0;
    logic              br_valid = 1'b0;
    logic [2:0]        br_cond = 3'b000;
    logic [OFF_W-1:0]  br_off = '0;
    logic              jmp_valid = 1'b0;
    logic [ADDR_W-1:0] jmp_target = '0;
    logic              halt_req = 1'b0;
    logic [ADDR_W-1:0] pc, link_addr;
    logic [2:0]        flags_q;
    logic              taken, flush, halted;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = running, 1 = squashing, 2 = halted
    int         m_pc;
    logic [2:0] m_fl;
    int         m_mode;

    pc_branch_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flags_we(flags_we),
        .zero_in(zero_in), .neg_in(neg_in), .par_in(par_in),
        .br_valid(br_valid), .br_cond(br_cond), .br_off(br_off),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target), .halt_req(halt_req),
        .pc(pc), .link_addr(link_addr), .flags_q(flags_q),
        .taken(taken), .flush(flush), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
        bit z, n, p;
        z = f[2]; n = f[1]; p = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return p;
            3'd6: return !p;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_taken();
        logic [2:0] f;
        f = flags_we ? {zero_in, neg_in, par_in} : m_fl;
        return (m_mode == 0) && (jmp_valid || (br_valid && cond_ok(br_cond, f)));
    endfunction

    function automatic logic [ADDR_W+4:0] model_regs();
        logic [ADDR_W-1:0] p;
        p = ADDR_W'(m_pc);
        return {p, m_fl, m_mode == 1, m_mode == 2};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_fl = 3'b000; m_mode = 0;
    endtask

    task automatic model_step();
        bit tk;
        tk = model_taken();
        if (stall) return;
        if (m_mode == 0) begin
            if (flags_we) m_fl = {zero_in, neg_in, par_in};
            if (halt_req) m_mode = 2;
            else if (jmp_valid) begin m_pc = int'(jmp_target); m_mode = 1; end
            else if (tk) begin m_pc = (m_pc + int'($signed(br_off))) & (PC_MOD - 1); m_mode = 1; end
            else m_pc = (m_pc + 1) % PC_MOD;
        end else if (m_mode == 1) begin
            m_pc = (m_pc + 1) % PC_MOD;
            m_mode = 0;
        end
    endtask

    task automatic idle_inputs();
        stall = 0; flags_we = 0; zero_in = 0; neg_in = 0; par_in = 0;
        br_valid = 0; br_cond = 3'b000; br_off = '0;
        jmp_valid = 0; jmp_target = '0; halt_req = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        total++;
        if ({pc, flags_q, flush, halted} !== 15'h0) begin
            bad++; $display("FAIL reset_vals got=%h want=%h", {pc, flags_q, flush, halted}, 15'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (pc !== 10'h000) begin bad++; $display("FAIL reset_release pc got=%h want=000", pc); end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if ({pc, flags_q, flush, halted} !== {10'(i), 3'b000, 1'b0, 1'b0}) begin
                bad++; $display("FAIL free_run[%0d] got=%h want=%h", i, {pc, flags_q, flush, halted}, {10'(i), 5'b0});
            end
        end
        total++;
        if (link_addr !== 10'h006) begin bad++; $display("FAIL link_addr got=%h want=006", link_addr); end
    endtask

    task automatic test_bypass_branch();
        while (m_pc != 16) tick();
        total++;
        if (pc !== 10'h010) begin bad++; $display("FAIL bypass_setup pc got=%h want=010", pc); end
        br_valid = 1; br_cond = 3'b001; br_off = 8'hFC;
        flags_we = 1; zero_in = 1; neg_in = 0; par_in = 0;
        #2;
        total++;
        if (taken !== 1'b1) begin bad++; $display("FAIL bypass_taken got=%b want=1", taken); end
        tick();
        idle_inputs();
        total++;
        if ({pc, flush, flags_q} !== {10'h00C, 1'b1, 3'b100}) begin
            bad++; $display("FAIL bypass_redirect got=%h/%b/%b want=00c/1/100", pc, flush, flags_q);
        end
        tick();
        total++;
        if ({pc, flush} !== {10'h00D, 1'b0}) begin
            bad++; $display("FAIL bypass_after got=%h/%b want=00d/0", pc, flush);
        end
    endtask

    task automatic test_cond_no_bypass();
        br_valid = 1; br_cond = 3'b011; br_off = 8'd5;
        #2;
        total++;
        if (taken !== 1'b0) begin bad++; $display("FAIL cond_n_taken got=%b want=0", taken); end
        tick();
        total++;
        if (pc !== 10'h00E) begin bad++; $display("FAIL cond_n_pc got=%h want=00e", pc); end
        br_cond = 3'b100;
        #2;
        total++;
        if (taken !== 1'b1) begin bad++; $display("FAIL cond_nn_taken got=%b want=1", taken); end
        tick();
        idle_inputs();
        total++;
        if ({pc, flush} !== {10'h013, 1'b1}) begin bad++; $display("FAIL cond_nn_pc got=%h/%b want=013/1", pc, flush); end
        tick();
        total++;
        if ({pc, flush} !== {10'h014, 1'b0}) begin bad++; $display("FAIL cond_nn_after got=%h/%b want=014/0", pc, flush); end
    endtask

    task automatic test_jump_wrap();
        jmp_valid = 1; jmp_target = 10'h3FF; br_valid = 1; br_cond = 3'b000; br_off = 8'd7;
        #2;
        total++;
        if (taken !== 1'b1) begin bad++; $display("FAIL jmp_taken got=%b want=1", taken); end
        tick();
        idle_inputs();
        total++;
        if ({pc, flush} !== {10'h3FF, 1'b1}) begin bad++; $display("FAIL jmp_pc got=%h/%b want=3ff/1", pc, flush); end
        tick();
        total++;
        if (pc !== 10'h000) begin bad++; $display("FAIL wrap0 got=%h want=000", pc); end
        tick();
        total++;
        if ({pc, flush} !== {10'h001, 1'b0}) begin bad++; $display("FAIL wrap1 got=%h/%b want=001/0", pc, flush); end
    endtask

    task automatic test_stall();
        logic [ADDR_W+4:0] held;
        held = {pc, flags_q, flush, halted};
        stall = 1; br_valid = 1; br_cond = 3'b000; br_off = 8'd3;
        flags_we = 1; zero_in = 0; neg_in = 1; par_in = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if (taken !== 1'b1) begin bad++; $display("FAIL stall_taken[%0d] got=%b want=1", i, taken); end
            tick();
            total++;
            if ({pc, flags_q, flush, halted} !== held) begin
                bad++; $display("FAIL stall_hold[%0d] got=%h want=%h", i, {pc, flags_q, flush, halted}, held);
            end
        end
        stall = 0;
        tick();
        total++;
        if ({pc, flags_q, flush} !== {10'h004, 3'b011, 1'b1}) begin
            bad++; $display("FAIL stall_release got=%h/%b/%b want=004/011/1", pc, flags_q, flush);
        end
        flags_we = 0; br_off = 8'd20;
        #2;
        total++;
        if (taken !== 1'b0) begin bad++; $display("FAIL flush_squash_taken got=%b want=0", taken); end
        tick();
        idle_inputs();
        total++;
        if ({pc, flush} !== {10'h005, 1'b0}) begin bad++; $display("FAIL flush_squash_pc got=%h/%b want=005/0", pc, flush); end
    endtask

    task automatic test_halt();
        logic [ADDR_W-1:0] frozen;
        frozen = pc;
        halt_req = 1; jmp_valid = 1; jmp_target = 10'h155;
        tick();
        total++;
        if ({halted, pc} !== {1'b1, frozen}) begin bad++; $display("FAIL halt_enter got=%b/%h want=1/%h", halted, pc, frozen); end
        for (int i = 0; i < 10; i++) begin
            {stall, flags_we, zero_in, neg_in, par_in, br_valid, jmp_valid, halt_req} = 8'($urandom);
            br_cond = 3'($urandom); br_off = 8'($urandom); jmp_target = 10'($urandom);
            #2;
            total++;
            if (taken !== 1'b0) begin bad++; $display("FAIL halt_taken[%0d] got=%b want=0", i, taken); end
            tick();
            total++;
            if ({pc, halted} !== {frozen, 1'b1}) begin bad++; $display("FAIL halt_frozen[%0d] got=%h/%b want=%h/1", i, pc, halted, frozen); end
        end
        test_reset();
        total++;
        if ({halted, flush} !== 2'b00) begin bad++; $display("FAIL halt_exit got=%b%b want=00", halted, flush); end
        tick();
        total++;
        if (pc !== 10'h001) begin bad++; $display("FAIL halt_exit_run got=%h want=001", pc); end
    endtask

    task automatic test_random();
        int halt_cycles;
        halt_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            stall     = ($urandom_range(0, 3) == 0);
            flags_we  = 1'($urandom);
            {zero_in, neg_in, par_in} = 3'($urandom);
            br_valid  = 1'($urandom);
            br_cond   = 3'($urandom);
            br_off    = 8'($urandom);
            jmp_valid = ($urandom_range(0, 5) == 0);
            jmp_target = 10'($urandom);
            halt_req  = ($urandom_range(0, 60) == 0);
            #2;
            total++;
            if (taken !== model_taken()) begin bad++; $display("FAIL rand_taken[%0d] got=%b want=%b", i, taken, model_taken()); end
            total++;
            if (link_addr !== ADDR_W'(m_pc + 1)) begin bad++; $display("FAIL rand_link[%0d] got=%h want=%h", i, link_addr, ADDR_W'(m_pc + 1)); end
            tick();
            total++;
            if ({pc, flags_q, flush, halted} !== model_regs()) begin
                bad++; $display("FAIL rand_regs[%0d] got=%h want=%h", i, {pc, flags_q, flush, halted}, model_regs());
            end
            halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
            if (halt_cycles > 6) begin
                test_reset();
                halt_cycles = 0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_bypass_branch();
        test_cond_no_bypass();
        test_jump_wrap();
        test_stall();
        test_halt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
